// File: rtl/rom_download_router.sv
// rom_download_router: qualifies ROM-index ioctl downloads, decodes each byte
// into one of four ROM regions with a region-relative address, registers the
// write for the loaders, counts bytes, and holds the core in reset until a
// complete, correctly sized image has arrived.
//
// Handshake: ioctl_wr is a one-cycle strobe with no backpressure. dn_wr is a
// one-cycle valid with no ready; the loaders must take every byte on the
// cycle dn_wr is high. dn_sel/dn_addr/dn_data hold between strobes.
module rom_download_router #(
  parameter logic [24:0] BASE1   = 25'h08000,
  parameter logic [24:0] BASE2   = 25'h0C000,
  parameter logic [24:0] BASE3   = 25'h14000,
  parameter logic [24:0] TOTAL   = 25'h24000,
  parameter logic [7:0]  ROM_IDX = 8'd0
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        dn_wr,
  output logic [3:0]  dn_sel,
  output logic [24:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        rom_ready,
  output logic        core_hold,
  output logic        dl_error,
  output logic [24:0] byte_cnt,
  output logic [1:0]  fsm_state
);

  localparam logic [24:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        rom_dl;
  logic        rom_dl_q;
  logic        dl_rise;
  logic        dl_fall;
  logic        wr_acc;
  logic        in_range;
  logic [3:0]  sel_c;
  logic [24:0] off_c;
  logic [24:0] cnt_nxt;
  logic        err_nxt;
  logic        ready_nxt;

  assign rom_dl    = ioctl_download & (ioctl_index == ROM_IDX);
  assign dl_rise   = rom_dl & ~rom_dl_q;
  assign dl_fall   = ~rom_dl & rom_dl_q;
  assign wr_acc    = ioctl_wr & rom_dl;
  assign in_range  = ioctl_addr < TOTAL;
  assign fsm_state = state;

  // Region decode: pick the highest base not above the address and re-base.
  always_comb begin
    sel_c = 4'b0001;
    off_c = ioctl_addr;
    if (ioctl_addr >= BASE3) begin
      sel_c = 4'b1000;
      off_c = ioctl_addr - BASE3;
    end else if (ioctl_addr >= BASE2) begin
      sel_c = 4'b0100;
      off_c = ioctl_addr - BASE2;
    end else if (ioctl_addr >= BASE1) begin
      sel_c = 4'b0010;
      off_c = ioctl_addr - BASE1;
    end
  end

  // Next download status: a new download clears the status before this
  // cycle's byte is counted; the end of a load judges the finished count.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = byte_cnt;
    err_nxt   = dl_error;
    ready_nxt = rom_ready;
    if (dl_rise) begin
      state_nxt = LOAD;
      cnt_nxt   = '0;
      err_nxt   = 1'b0;
      ready_nxt = 1'b0;
    end
    if (wr_acc) begin
      if (in_range) begin
        if (cnt_nxt != CNT_MAX) cnt_nxt = cnt_nxt + 25'd1;
      end else begin
        err_nxt = 1'b1;
      end
    end
    // dl_error can only be set inside LOAD by an out-of-range byte here.
    if (state == LOAD && dl_fall) begin
      state_nxt = DONE;
      if (byte_cnt == TOTAL && !dl_error) ready_nxt = 1'b1;
      else                                err_nxt   = 1'b1;
    end
  end

  // State, status and write-port registers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= IDLE;
      rom_dl_q  <= 1'b0;
      dn_wr     <= 1'b0;
      dn_sel    <= '0;
      dn_addr   <= '0;
      dn_data   <= '0;
      rom_ready <= 1'b0;
      core_hold <= 1'b1;
      dl_error  <= 1'b0;
      byte_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      rom_dl_q  <= rom_dl;
      dn_wr     <= wr_acc & in_range;
      if (wr_acc & in_range) begin
        dn_sel  <= sel_c;
        dn_addr <= off_c;
        dn_data <= ioctl_dout;
      end
      rom_ready <= ready_nxt;
      core_hold <= ~ready_nxt;
      dl_error  <= err_nxt;
      byte_cnt  <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_rom_download_router.sv
// Bench for rom_download_router. The region map is scaled down by 64 so that
// complete images stream in a few thousand cycles; the decode structure and
// boundaries keep the same proportions as the real map.
module tb_rom_download_router;

  localparam logic [24:0] B1  = 25'h200;
  localparam logic [24:0] B2  = 25'h300;
  localparam logic [24:0] B3  = 25'h500;
  localparam logic [24:0] TOT = 25'h900;
  localparam int          W   = 37;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        dn_wr;
  logic [3:0]  dn_sel;
  logic [24:0] dn_addr;
  logic [7:0]  dn_data;
  logic        rom_ready;
  logic        core_hold;
  logic        dl_error;
  logic [24:0] byte_cnt;
  logic [1:0]  fsm_state;

  rom_download_router #(
    .BASE1(B1), .BASE2(B2), .BASE3(B3), .TOTAL(TOT), .ROM_IDX(8'd0)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .dn_wr(dn_wr), .dn_sel(dn_sel), .dn_addr(dn_addr),
    .dn_data(dn_data), .rom_ready(rom_ready), .core_hold(core_hold),
    .dl_error(dl_error), .byte_cnt(byte_cnt), .fsm_state(fsm_state)
  );

  // Clock
  always #5 clk_sys = ~clk_sys;

  // Scoreboard and reference model state
  logic [W-1:0] exp_q[$];
  int           n_tests = 0;
  int           n_fail = 0;
  int           hits[4];
  bit           m_prev_dl, m_loading, m_oor, m_err, m_ready;
  logic [24:0]  m_cnt;
  logic [3:0]   h_sel;
  logic [24:0]  h_off;
  logic [7:0]   h_data;
  logic [24:0]  bases[4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prev_dl = 0; m_loading = 0; m_oor = 0; m_err = 0; m_ready = 0;
    m_cnt = '0; h_sel = '0; h_off = '0; h_data = '0;
    exp_q.delete();
  endtask

  // Reference: apply the download rules to the inputs seen at this edge.
  task automatic model(input bit dl, input logic [7:0] idx, input bit wr,
                       input logic [24:0] addr, input logic [7:0] data);
    bit rom_dl;
    int r;
    rom_dl = dl && (idx == 8'd0);
    if (rom_dl && !m_prev_dl) begin
      m_loading = 1; m_cnt = '0; m_err = 0; m_ready = 0; m_oor = 0;
    end
    if (rom_dl && wr) begin
      if (addr < TOT) begin
        r = 0;
        for (int k = 0; k < 4; k++) if (addr >= bases[k]) r = k;
        exp_q.push_back({4'(1 << r), 25'(addr - bases[r]), data});
        if (m_cnt != 25'h1FFFFFF) m_cnt = m_cnt + 1;
      end else begin
        m_err = 1; m_oor = 1;
      end
    end
    if (!rom_dl && m_prev_dl && m_loading) begin
      m_loading = 0;
      if (m_cnt == TOT && !m_oor) m_ready = 1;
      else m_err = 1;
    end
    m_prev_dl = rom_dl;
  endtask

  task automatic check_cycle();
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      {h_sel, h_off, h_data} = e;
      chk("dn_wr", 32'(dn_wr), 32'd1);
      for (int k = 0; k < 4; k++) if (dn_sel == 4'(1 << k)) hits[k]++;
    end else begin
      chk("dn_wr_idle", 32'(dn_wr), 32'd0);
    end
    chk("dn_sel", 32'(dn_sel), 32'(h_sel));
    chk("dn_addr", 32'(dn_addr), 32'(h_off));
    chk("dn_data", 32'(dn_data), 32'(h_data));
    chk("rom_ready", 32'(rom_ready), 32'(m_ready));
    chk("core_hold", 32'(core_hold), 32'(!m_ready));
    chk("dl_error", 32'(dl_error), 32'(m_err));
    chk("byte_cnt", 32'(byte_cnt), 32'(m_cnt));
  endtask

  // Driver: one clock with the given inputs, then model and check.
  task automatic step(input bit dl, input logic [7:0] idx, input bit wr,
                      input logic [24:0] addr, input logic [7:0] data, input bit rst = 0);
    reset = rst; ioctl_download = dl; ioctl_index = idx; ioctl_wr = wr;
    ioctl_addr = addr; ioctl_dout = data;
    @(posedge clk_sys);
    #1;
    if (rst) model_reset();
    else model(dl, idx, wr, addr, data);
    check_cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'd0, 0, '0, '0);
  endtask

  // Stream bytes 0..n-1 at index 0 with random gaps; optionally linger
  // before dropping download, otherwise drop right after the last byte.
  task automatic load(input int n, input int gap_max, input bit linger, input bit drop = 1);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gap_max)) step(1, 8'd0, 0, '0, '0);
      step(1, 8'd0, 1, 25'(i), 8'($urandom));
    end
    if (linger) repeat ($urandom_range(1, 4)) step(1, 8'd0, 0, '0, '0);
    if (drop) step(0, 8'd0, 0, '0, '0);
  endtask

  task automatic other_index_writes(input int n);
    for (int i = 0; i < n; i++)
      step(1, 8'd254, $urandom_range(0, 1), 25'($urandom_range(0, 32'(TOT))), 8'($urandom));
    step(0, 8'd254, 0, '0, '0);
  endtask

  initial begin
    bases[0] = '0; bases[1] = B1; bases[2] = B2; bases[3] = B3;
    model_reset();

    // Reset values
    step(0, 8'd0, 0, '0, '0, 1);
    step(0, 8'd0, 0, '0, '0, 1);
    chk("rst_dn_wr", 32'(dn_wr), 32'd0);
    chk("rst_rom_ready", 32'(rom_ready), 32'd0);
    chk("rst_core_hold", 32'(core_hold), 32'd1);
    chk("rst_byte_cnt", 32'(byte_cnt), 32'd0);
    idle(2);

    // Full image with random gaps and data
    for (int k = 0; k < 4; k++) hits[k] = 0;
    load(int'(TOT), 1, 1);
    chk("t1_ready", 32'(rom_ready), 32'd1);
    chk("t1_hold", 32'(core_hold), 32'd0);
    chk("t1_err", 32'(dl_error), 32'd0);
    chk("t1_cnt", 32'(byte_cnt), 32'(TOT));
    chk("t1_hits0", 32'(hits[0]), 32'(B1));
    chk("t1_hits1", 32'(hits[1]), 32'(B2 - B1));
    chk("t1_hits2", 32'(hits[2]), 32'(B3 - B2));
    chk("t1_hits3", 32'(hits[3]), 32'(TOT - B3));
    idle(3);

    // Single write into region 2
    step(1, 8'd0, 0, '0, '0);
    step(1, 8'd0, 1, B2 + 25'd5, 8'hA5);
    chk("t2_wr", 32'(dn_wr), 32'd1);
    chk("t2_sel", 32'(dn_sel), 32'h4);
    chk("t2_addr", 32'(dn_addr), 32'd5);
    chk("t2_data", 32'(dn_data), 32'hA5);
    step(1, 8'd0, 0, '0, '0);
    chk("t2_wr_off", 32'(dn_wr), 32'd0);
    step(0, 8'd0, 0, '0, '0);
    idle(2);

    // Short image
    load(int'(TOT) - 1, 0, 0);
    chk("t3_err", 32'(dl_error), 32'd1);
    chk("t3_ready", 32'(rom_ready), 32'd0);
    chk("t3_hold", 32'(core_hold), 32'd1);
    idle(2);

    // Out-of-range byte
    step(1, 8'd0, 1, TOT, 8'h3C);
    chk("t3_oor_wr", 32'(dn_wr), 32'd0);
    chk("t3_oor_err", 32'(dl_error), 32'd1);
    step(0, 8'd0, 0, '0, '0);
    idle(2);

    // Other-index traffic around a good load
    load(int'(TOT), 0, 0);
    other_index_writes(40);
    chk("t4_ready", 32'(rom_ready), 32'd1);
    chk("t4_cnt", 32'(byte_cnt), 32'(TOT));
    other_index_writes(20);
    load(int'(TOT), 0, 1);
    other_index_writes(40);
    chk("t4_ready2", 32'(rom_ready), 32'd1);

    // Reset in the middle of a load, then a full reload
    load(25'h40, 0, 0, 0);
    step(1, 8'd0, 0, '0, '0, 1);
    chk("t5_ready", 32'(rom_ready), 32'd0);
    chk("t5_hold", 32'(core_hold), 32'd1);
    chk("t5_cnt", 32'(byte_cnt), 32'd0);
    chk("t5_err", 32'(dl_error), 32'd0);
    step(0, 8'd0, 0, '0, '0);
    idle(2);
    load(int'(TOT), 1, 0);
    chk("t5_reload", 32'(rom_ready), 32'd1);
    idle(2);

    // Last byte on the final high cycle of the download
    load(int'(TOT), 0, 0);
    chk("t6_ready", 32'(rom_ready), 32'd1);
    chk("t6_cnt", 32'(byte_cnt), 32'(TOT));
    idle(2);

    // Random addresses, some beyond the image, with random strobes
    step(1, 8'd0, 0, '0, '0);
    for (int i = 0; i < 300; i++)
      step(1, 8'd0, $urandom_range(0, 1), 25'($urandom_range(0, 32'(TOT) + 32)), 8'($urandom));
    step(0, 8'd0, 0, '0, '0);
    chk("rand_err", 32'(dl_error), 32'd1);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
